// File: rtl/starfield_parallax_if.sv
// CPU register bus and per-pixel video-mixer outputs of the starfield block.
interface starfield_parallax_if;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic       write;
  logic       sf_on;
  logic [7:0] sf_star;
  logic [1:0] sf_layer;

  modport master (output addr, output data_in, output write,
                  input sf_on, input sf_star, input sf_layer);
  modport slave  (input addr, input data_in, input write,
                  output sf_on, output sf_star, output sf_layer);
endinterface

// File: rtl/starfield_parallax.sv
// Multi-layer scrolling LFSR starfield. Each layer restarts its LFSR from its
// seed at the start of every frame; the frame length (period) is stretched or
// shrunk by whole pixels/lines at each frame step, which makes the pattern
// appear to scroll. Layer 0 is nearest: brightest and highest priority.
module starfield_parallax #(
  parameter int H = 800,
  parameter int V = 525,
  parameter int LEN = 25,
  parameter logic [LEN-1:0] TAPS = 25'b1010000000000000000000000,
  parameter int LAYERS = 3,
  parameter logic [LAYERS*LEN-1:0] SEEDS =
    (LAYERS*LEN)'({4{25'h1FFFC00}} ^ {25'h0, 25'h0A5A5, 25'h15A5A, 25'h1F0F0}),
  parameter logic [LEN-1:0] MASK = 25'h1FFFF00
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic pause,
  starfield_parallax_if.slave bus
);

  localparam logic [LEN-1:0] FRAME_LAST = LEN'(H*V-1);

  logic [LAYERS-1:0] en_mask, p_mask, hdir, vdir;
  logic [14:0]       hspeed   [LAYERS];
  logic [14:0]       vspeed   [LAYERS];
  logic [15:0]       htimer   [LAYERS];
  logic [15:0]       vtimer   [LAYERS];
  logic [LEN-1:0]    cnt      [LAYERS];
  logic [LEN-1:0]    period_r [LAYERS];
  logic [LEN-1:0]    sreg     [LAYERS];

  logic [LAYERS-1:0] paused, hit;
  logic [23:0]       hres     [LAYERS];
  logic [23:0]       vres     [LAYERS];
  logic [LEN-1:0]    per_next [LAYERS];
  logic [7:0]        bright   [LAYERS];

  logic [2:0] wr_layer;
  logic       wr_layer_ok;
  logic       on_d, on_p1;
  logic [7:0] star_d, star_p1;
  logic [1:0] layer_d, layer_p1;

  // Fibonacci LFSR: shift left, feedback is the parity of the tapped bits.
  function automatic logic [LEN-1:0] lfsr_next(input logic [LEN-1:0] s);
    return {s[LEN-2:0], ^(s & TAPS)};
  endfunction

  // Sub-pixel accumulator: returns {new_timer, whole-pixel increment}.
  // Any accumulated value of 0xFF or more yields at least one whole step.
  function automatic logic [23:0] axis_step(input logic [15:0] timer,
                                            input logic [14:0] speed);
    logic [15:0] t;
    logic [7:0]  inc;
    t   = timer + {1'b0, speed};
    inc = 8'h00;
    if (t >= 16'h00FF) begin
      inc = (t[15:8] != 8'h00) ? t[15:8] : 8'h01;
      t   = t - {inc, 8'h00};
    end
    return {t, inc};
  endfunction

  // Next frame length minus one, wrapping modulo 2^LEN.
  function automatic logic [LEN-1:0] frame_period(input logic [7:0] hinc, input logic hd,
                                                  input logic [7:0] vinc, input logic vd);
    logic [LEN-1:0] lines, p;
    lines = vd ? LEN'(V) + LEN'(vinc) : LEN'(V) - LEN'(vinc);
    p     = LEN'(H) * lines;
    p     = hd ? p + LEN'(hinc) : p - LEN'(hinc);
    return p - LEN'(1);
  endfunction

  // Decode which layer block (0x08 + 4n) a CPU write targets.
  always_comb begin
    wr_layer    = bus.addr[4:2] - 3'd2;
    wr_layer_ok = bus.write & (bus.addr[4] | bus.addr[3]) & (int'(wr_layer) < LAYERS);
  end

  // CPU-visible control registers; new values are used from the next clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_mask <= '0;
      p_mask  <= '0;
      hdir    <= '0;
      vdir    <= '0;
      for (int n = 0; n < LAYERS; n++) begin
        hspeed[n] <= '0;
        vspeed[n] <= '0;
      end
    end else begin
      if (bus.write && bus.addr == 5'h00) en_mask <= bus.data_in[LAYERS-1:0];
      if (bus.write && bus.addr == 5'h01) p_mask  <= bus.data_in[LAYERS-1:0];
      for (int n = 0; n < LAYERS; n++) begin
        if (wr_layer_ok && wr_layer == 3'(n)) begin
          case (bus.addr[1:0])
            2'd0: begin
              hdir[n]         <= bus.data_in[7];
              hspeed[n][14:8] <= bus.data_in[6:0];
            end
            2'd1: hspeed[n][7:0] <= bus.data_in;
            2'd2: begin
              vdir[n]         <= bus.data_in[7];
              vspeed[n][14:8] <= bus.data_in[6:0];
            end
            default: vspeed[n][7:0] <= bus.data_in;
          endcase
        end
      end
    end
  end

  // Per-layer frame-step arithmetic and star detection from current LFSR state.
  always_comb begin
    for (int n = 0; n < LAYERS; n++) begin
      paused[n]   = pause & p_mask[n];
      hres[n]     = axis_step(htimer[n], paused[n] ? 15'd0 : hspeed[n]);
      vres[n]     = axis_step(vtimer[n], paused[n] ? 15'd0 : vspeed[n]);
      per_next[n] = paused[n] ? FRAME_LAST
                              : frame_period(hres[n][7:0], hdir[n], vres[n][7:0], vdir[n]);
      hit[n]      = en_mask[n] & (&(sreg[n] | ~MASK));
      bright[n]   = sreg[n][7:0] >> n;
    end
  end

  // Nearest (lowest-index) hitting layer wins; scan from far to near.
  always_comb begin
    on_d    = 1'b0;
    star_d  = 8'h00;
    layer_d = 2'd0;
    for (int n = LAYERS-1; n >= 0; n--) begin
      if (hit[n]) begin
        on_d    = 1'b1;
        star_d  = bright[n];
        layer_d = 2'(n);
      end
    end
  end

  // Pixel counters, LFSRs and scroll timers; advance only on pixel enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < LAYERS; n++) begin
        cnt[n]      <= '0;
        sreg[n]     <= SEEDS[n*LEN +: LEN];
        period_r[n] <= FRAME_LAST;
        htimer[n]   <= '0;
        vtimer[n]   <= '0;
      end
    end else if (en) begin
      for (int n = 0; n < LAYERS; n++) begin
        if (cnt[n] == period_r[n]) begin
          cnt[n]      <= '0;
          sreg[n]     <= SEEDS[n*LEN +: LEN];
          htimer[n]   <= hres[n][23:8];
          vtimer[n]   <= vres[n][23:8];
          period_r[n] <= per_next[n];
        end else begin
          cnt[n]  <= cnt[n] + LEN'(1);
          sreg[n] <= lfsr_next(sreg[n]);
        end
      end
    end
  end

  // Stage p1: registered mixer outputs, held while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      on_p1    <= 1'b0;
      star_p1  <= 8'h00;
      layer_p1 <= 2'd0;
    end else if (en) begin
      on_p1    <= on_d;
      star_p1  <= star_d;
      layer_p1 <= layer_d;
    end
  end

  assign bus.sf_on    = on_p1;
  assign bus.sf_star  = star_p1;
  assign bus.sf_layer = layer_p1;

endmodule

// File: tb/tb_starfield_parallax.sv
// Bench for starfield_parallax on a tiny 16x8 raster with a dense star mask.
// Layers 1 and 2 share a seed so their stars always coincide.
module tb_starfield_parallax;
  localparam int H = 16;
  localparam int V = 8;
  localparam int LEN = 25;
  localparam int LAYERS = 3;
  localparam logic [LEN-1:0] TAPS = 25'b1010000000000000000000000;
  localparam logic [LAYERS*LEN-1:0] TB_SEEDS = {25'h0ABCDE1, 25'h0ABCDE1, 25'h1234567};
  localparam logic [LEN-1:0] TB_MASK = 25'h1C00000;

  logic clk = 1'b0;
  logic rst, en, pause;
  starfield_parallax_if bus();

  starfield_parallax #(.H(H), .V(V), .LEN(LEN), .TAPS(TAPS), .LAYERS(LAYERS),
                       .SEEDS(TB_SEEDS), .MASK(TB_MASK))
    dut (.clk(clk), .rst(rst), .en(en), .pause(pause), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Star pattern of each layer: position k of a frame shows seq[n][k].
  logic [LEN-1:0] seq [LAYERS][256];

  // Reference model state.
  int m_en, m_pm;
  int m_hs [LAYERS], m_hd [LAYERS], m_vs [LAYERS], m_vd [LAYERS];
  int m_ht [LAYERS], m_vt [LAYERS], m_cnt [LAYERS], m_per [LAYERS];
  logic       e_on;
  logic [7:0] e_star;
  logic [1:0] e_layer;

  typedef struct {
    int hs; int hd; int vs; int vd; int pm; int pz; int cyc; int exp_per;
  } row_t;
  row_t rows [10];

  function automatic int axis(input int timer, input int speed, output int new_timer);
    int t, inc;
    t = (timer + speed) % 65536;
    inc = 0;
    if (t >= 255) begin
      inc = (t / 256 != 0) ? t / 256 : 1;
      t = (t - inc * 256 + 65536) % 65536;
    end
    new_timer = t;
    return inc;
  endfunction

  task automatic m_reset();
    m_en = 0; m_pm = 0;
    for (int n = 0; n < LAYERS; n++) begin
      m_hs[n] = 0; m_hd[n] = 0; m_vs[n] = 0; m_vd[n] = 0;
      m_ht[n] = 0; m_vt[n] = 0; m_cnt[n] = 0; m_per[n] = H*V - 1;
    end
    e_on = 1'b0; e_star = 8'h00; e_layer = 2'd0;
  endtask

  // Advance the model by one clk using the inputs currently driven.
  task automatic m_step();
    int win, a, d, l, f, hinc, vinc, nt;
    logic [7:0] b;
    bit pz;
    if (rst) begin
      m_reset();
    end else begin
      if (en) begin
        win = -1;
        for (int n = 0; n < LAYERS; n++)
          if (win < 0 && ((m_en >> n) & 1) == 1 && (seq[n][m_cnt[n]] & TB_MASK) == TB_MASK)
            win = n;
        if (win < 0) begin
          e_on = 1'b0; e_star = 8'h00; e_layer = 2'd0;
        end else begin
          b = seq[win][m_cnt[win]][7:0];
          e_on = 1'b1; e_star = b >> win; e_layer = 2'(win);
        end
        for (int n = 0; n < LAYERS; n++) begin
          if (m_cnt[n] == m_per[n]) begin
            pz = pause && ((m_pm >> n) & 1) == 1;
            hinc = axis(m_ht[n], pz ? 0 : m_hs[n], nt); m_ht[n] = nt;
            vinc = axis(m_vt[n], pz ? 0 : m_vs[n], nt); m_vt[n] = nt;
            m_per[n] = pz ? H*V - 1
                          : H * (V + (m_vd[n] != 0 ? vinc : -vinc)) + (m_hd[n] != 0 ? hinc : -hinc) - 1;
            m_cnt[n] = 0;
          end else begin
            m_cnt[n]++;
          end
        end
      end
      if (bus.write) begin
        a = int'(bus.addr); d = int'(bus.data_in);
        if (a == 0) m_en = d & ((1 << LAYERS) - 1);
        if (a == 1) m_pm = d & ((1 << LAYERS) - 1);
        if (a >= 8) begin
          l = (a - 8) / 4; f = (a - 8) % 4;
          if (l < LAYERS) begin
            case (f)
              0: begin m_hd[l] = d >> 7; m_hs[l] = (m_hs[l] & 255) | ((d & 127) << 8); end
              1: m_hs[l] = (m_hs[l] & 'h7F00) | d;
              2: begin m_vd[l] = d >> 7; m_vs[l] = (m_vs[l] & 255) | ((d & 127) << 8); end
              default: m_vs[l] = (m_vs[l] & 'h7F00) | d;
            endcase
          end
        end
      end
    end
  endtask

  task automatic cycle();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag);
    checks++;
    if (bus.sf_on !== e_on || bus.sf_star !== e_star || bus.sf_layer !== e_layer) begin
      errors++;
      $display("FAIL %s: got on=%0b star=%02h layer=%0d, expected on=%0b star=%02h layer=%0d",
               tag, bus.sf_on, bus.sf_star, bus.sf_layer, e_on, e_star, e_layer);
    end
  endtask

  task automatic check_val(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic run(input int ncyc, input string tag);
    for (int i = 0; i < ncyc; i++) begin
      cycle();
      check_out(tag);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; pause = 1'b0; bus.write = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    bus.addr = 5'(a); bus.data_in = 8'(d); bus.write = 1'b1;
    cycle();
    check_out("write_hold");
    bus.write = 1'b0;
  endtask

  initial begin
    logic [LEN-1:0] s;
    logic f1 [128];
    int l1, a;
    rst = 1'b1; en = 1'b0; pause = 1'b0;
    bus.addr = '0; bus.data_in = '0; bus.write = 1'b0;
    m_reset();

    for (int n = 0; n < LAYERS; n++) begin
      s = TB_SEEDS[n*LEN +: LEN];
      for (int i = 0; i < 256; i++) begin
        seq[n][i] = s;
        s = {s[LEN-2:0], ^(s & TAPS)};
      end
    end

    // Frame-step arithmetic on layer 0, expected periods worked out by hand for a 16x8 raster.
    rows[0] = '{0,     0, 0,     0, 0, 0, 128, 127};
    rows[1] = '{'h100, 1, 0,     0, 0, 0, 128, 128};
    rows[2] = '{'h100, 0, 0,     0, 0, 0, 128, 126};
    rows[3] = '{0,     0, 'h080, 0, 0, 0, 128, 127};
    rows[4] = '{0,     0, 'h080, 0, 0, 0, 256, 111};
    rows[5] = '{0,     0, 'h100, 1, 0, 0, 128, 143};
    rows[6] = '{'h280, 1, 0,     0, 0, 0, 128, 129};
    rows[7] = '{'h100, 1, 0,     0, 1, 1, 128, 127};
    rows[8] = '{'h280, 1, 0,     0, 0, 0, 258, 130};
    rows[9] = '{'h100, 1, 'h100, 0, 0, 0, 128, 112};
    for (int r = 0; r < 10; r++) begin
      do_reset();
      check_val("reset_on", int'(bus.sf_on), 0);
      check_val("reset_star", int'(bus.sf_star), 0);
      wr(8'h08, (rows[r].hd << 7) | (rows[r].hs >> 8));
      wr(8'h09, rows[r].hs & 255);
      wr(8'h0A, (rows[r].vd << 7) | (rows[r].vs >> 8));
      wr(8'h0B, rows[r].vs & 255);
      wr(8'h00, 1);
      wr(8'h01, rows[r].pm);
      pause = rows[r].pz[0];
      en = 1'b1;
      run(rows[r].cyc, "row_pixels");
      check_val($sformatf("row%0d_period", r), int'(dut.period_r[0]), rows[r].exp_per);
      en = 1'b0;
    end

    // Static layer repeats identically from frame to frame.
    do_reset();
    wr(8'h00, 1);
    en = 1'b1;
    for (int i = 0; i < 128; i++) begin
      cycle(); check_out("frame1"); f1[i] = bus.sf_on;
    end
    for (int i = 0; i < 128; i++) begin
      cycle(); check_out("frame2");
      check_val("frame_repeat", int'(bus.sf_on), int'(f1[i]));
    end

    // Coincident hits on layers 1 and 2 resolve to layer 1.
    do_reset();
    wr(8'h00, 7);
    en = 1'b1;
    l1 = 0;
    for (int i = 0; i < 128; i++) begin
      cycle(); check_out("coincide");
      if (bus.sf_layer == 2'd1) l1++;
    end
    checks++;
    if (l1 == 0) begin
      errors++;
      $display("FAIL coincide_count: got 0 layer-1 pixels, expected at least 1");
    end

    // Pause mask freezes layer 1 only.
    do_reset();
    wr(8'h08, 8'h81); wr(8'h09, 0); wr(8'h0C, 8'h81); wr(8'h0D, 0);
    wr(8'h00, 3); wr(8'h01, 2);
    en = 1'b1;
    run(60, "pause_pre");
    pause = 1'b1;
    run(68, "pause_post");
    check_val("pause_l0_period", int'(dut.period_r[0]), 128);
    check_val("pause_l1_period", int'(dut.period_r[1]), 127);
    pause = 1'b0;

    // Reset wins over a simultaneous write and discards earlier settings.
    do_reset();
    wr(8'h08, 8'h81); wr(8'h09, 0); wr(8'h00, 1);
    en = 1'b1;
    run(30, "pre_rst");
    rst = 1'b1; bus.addr = 5'h00; bus.data_in = 8'h07; bus.write = 1'b1;
    cycle();
    rst = 1'b0; bus.write = 1'b0;
    check_val("rst_on", int'(bus.sf_on), 0);
    check_val("rst_layer", int'(bus.sf_layer), 0);
    check_val("rst_cnt", int'(dut.cnt[0]), 0);
    run(128, "post_rst");
    check_val("rst_period", int'(dut.period_r[0]), 127);
    check_val("rst_cnt_wrap", int'(dut.cnt[0]), 0);

    // Randomized enables, pauses and register writes against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom % 4) != 0;
      if ($urandom % 64 == 0) pause = ~pause;
      if ($urandom % 12 == 0) begin
        a = $urandom % 32;
        bus.addr = 5'(a);
        if (a >= 8 && (a % 2) == 0)      bus.data_in = {1'($urandom), 5'b0, 2'($urandom)};
        else if (a >= 8)                 bus.data_in = {2'($urandom), 6'b0};
        else                             bus.data_in = 8'($urandom);
        bus.write = 1'b1;
      end
      cycle();
      check_out("random");
      bus.write = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
